decode_stage: RTL
=================

# decode_stage

Second stage of the word-addressed RISC-V pipeline. Takes the instruction, PC and PC+1 produced by the fetch stage and decodes them into control signals and a sign-extended immediate. Holds the 32×32 register file, written from writeback, and registers everything into the ID/EX pipeline register that feeds execute. Supports flush (bubble insertion) and stall (hold) for the hazard unit.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREG`, 32, register-file depth; x0 hardwired zero

Ports:
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous reset, active-high
- `Instr_D` in 32: instruction from the IF/ID register
- `PC_D` in 32: PC of `Instr_D`
- `PCPlusD` in 32: `PC_D` + 1 (word-addressed)
- `RegWriteW` in 1: writeback enable
- `RDW` in 5: writeback destination
- `ResultW` in 32: writeback data
- `FlushE` in 1: load a bubble into ID/EX
- `StallE` in 1: hold ID/EX contents
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE` out 1 each: registered control
- `ResultSrcE` out 2: 00 ALU, 01 memory, 10 PC+1
- `ALUControlE` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt
- `RD1_E`, `RD2_E` out 32: register operands
- `ImmExtE` out 32: sign-extended immediate
- `RS1_E`, `RS2_E`, `RD_E` out 5: register indices, for forwarding
- `PCE`, `PCPlusE` out 32: passed-through PCs
- `IllegalE` out 1: unsupported opcode flag

## Operation
- Opcode decode (`Instr_D[6:0]`):
  - 0000011 lw: RegWrite, ALUSrc, ResultSrc=01, I-imm, add
  - 0100011 sw: MemWrite, ALUSrc, S-imm, add
  - 0110011 R-type: RegWrite, ALU op from funct3/funct7
  - 0010011 I-ALU: RegWrite, ALUSrc, I-imm, ALU op from funct3
  - 1100011 beq: Branch, B-imm, sub
  - 1101111 jal: RegWrite, Jump, ResultSrc=10, J-imm
- Any other opcode: all control outputs 0 and `IllegalE`=1.
- ALU op from funct3:
  - 000 → add, or sub when R-type and funct7[5]=1
  - 010 → slt
  - 110 → or
  - 111 → and
  - Other funct3 values on R-type or I-ALU → illegal
- Immediates are sign-extended from `Instr_D[31]`:
  - I = [31:20]
  - S = {[31:25],[11:7]}
  - B = {[31],[7],[30:25],[11:8],0}
  - J = {[31],[19:12],[20],[30:21],0}
- Register file:
  - Write at the rising edge when `RegWriteW`=1 and `RDW`≠0.
  - Reads are combinational.
  - Write-through bypass: when `RegWriteW`=1, `RDW`≠0 and `RDW` equals the read index, the read returns `ResultW` in the same cycle.
  - Reading x0 always returns 0.
- ID/EX register update priority: `rst` > `FlushE` > `StallE` > load.
  - Flush: every ID/EX field is set to 0.
  - Stall: every field keeps its value.

## Timing
- On `rst`=1 at a clock edge, all outputs and all 32 register-file entries become 0 after that edge.
- Decode and the register read are combinational in cycle N. Outputs are valid after edge N+1, a latency of 1.
- Writeback and decode of a dependent instruction in the same cycle: the bypass delivers the new value, so no extra cycle is needed.
- `FlushE` and `StallE` both high: flush wins.
- Register-file writes happen during stall and flush. Only the ID/EX register is held or cleared.
- `rst` asserted mid-stream: the next edge clears everything, regardless of `StallE`/`FlushE`.

## Test plan
- Reset → after one edge with `rst`=1, all outputs are 0. Reading x1..x31 returns 0.
- Write x5=0xDEADBEEF, then decode `add x6,x5,x5` (0x00528333) → `RD1_E`=`RD2_E`=0xDEADBEEF, `RegWriteE`=1, `ALUControlE`=000, `RD_E`=6.
- Same cycle: `RegWriteW`=1, `RDW`=7, `ResultW`=0x1234, and decode `lw x8,-4(x7)` (0xFFC3A403) → `RD1_E`=0x1234, `ImmExtE`=0xFFFFFFFC, `ResultSrcE`=01, `ALUSrcE`=1.
- Write x0 with 0xFFFFFFFF, then read x0 → 0. Decode `beq` with offset −8 → `BranchE`=1, `ImmExtE`=0xFFFFFFF8, `ALUControlE`=001.
- Load `jal` with `PC_D`=0x10, then assert `StallE` for 3 cycles while `Instr_D` changes → outputs hold `JumpE`=1, `PCE`=0x10, `PCPlusE`=0x11. Assert `FlushE` together with `StallE` → next edge gives all outputs 0.
- Opcode 0x7F → `IllegalE`=1, all control outputs 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Bundle between fetch/hazard/writeback and the decode stage, plus the ID/EX
// outputs that feed execute.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic [31:0]      Instr_D;
   logic [XLEN-1:0]  PC_D;
   logic [XLEN-1:0]  PCPlusD;
   logic             RegWriteW;
   logic [4:0]       RDW;
   logic [XLEN-1:0]  ResultW;
   logic             FlushE;
   logic             StallE;

   logic             RegWriteE;
   logic             MemWriteE;
   logic             JumpE;
   logic             BranchE;
   logic             ALUSrcE;
   logic [1:0]       ResultSrcE;
   logic [2:0]       ALUControlE;
   logic [XLEN-1:0]  RD1_E;
   logic [XLEN-1:0]  RD2_E;
   logic [XLEN-1:0]  ImmExtE;
   logic [4:0]       RS1_E;
   logic [4:0]       RS2_E;
   logic [4:0]       RD_E;
   logic [XLEN-1:0]  PCE;
   logic [XLEN-1:0]  PCPlusE;
   logic             IllegalE;

   modport master (
      output Instr_D, PC_D, PCPlusD, RegWriteW, RDW, ResultW, FlushE, StallE,
      input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
             ALUControlE, RD1_E, RD2_E, ImmExtE, RS1_E, RS2_E, RD_E, PCE,
             PCPlusE, IllegalE
   );

   modport slave (
      input  Instr_D, PC_D, PCPlusD, RegWriteW, RDW, ResultW, FlushE, StallE,
      output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
             ALUControlE, RD1_E, RD2_E, ImmExtE, RS1_E, RS2_E, RD_E, PCE,
             PCPlusE, IllegalE
   );
endinterface

// File: rtl/decode_stage.sv
// RISC-V decode stage: control/immediate decode, write-through register file
// and the ID/EX pipeline register with flush/stall.
module decode_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input logic          clk,
   input logic          rst,
   decode_stage_if.slave bus
);
   localparam int AW = $clog2(NREG);

   typedef struct packed {
      logic            reg_write;
      logic            mem_write;
      logic            jump;
      logic            branch;
      logic            alu_src;
      logic [1:0]      result_src;
      logic [2:0]      alu_ctrl;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus;
      logic            illegal;
   } idex_t;

   idex_t           idex_d, idex_q;
   logic [XLEN-1:0] rf_q [NREG];

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rs1, rs2;
   logic       rf_we;

   assign opcode = bus.Instr_D[6:0];
   assign funct3 = bus.Instr_D[14:12];
   assign rs1    = bus.Instr_D[19:15];
   assign rs2    = bus.Instr_D[24:20];
   assign rf_we  = bus.RegWriteW && (bus.RDW != 5'd0);

   // Reads bypass a same-cycle writeback so a dependent instruction needs no stall.
   function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
      if (idx == 5'd0)
         return '0;
      else if (rf_we && (bus.RDW == idx))
         return bus.ResultW;
      else
         return rf_q[idx[AW-1:0]];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[bus.RDW[AW-1:0]] <= bus.ResultW;
      end
   end

   always_comb begin
      logic            alu_ok;
      logic [2:0]      alu_op;
      logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

      imm_i = {{(XLEN-12){bus.Instr_D[31]}}, bus.Instr_D[31:20]};
      imm_s = {{(XLEN-12){bus.Instr_D[31]}}, bus.Instr_D[31:25], bus.Instr_D[11:7]};
      imm_b = {{(XLEN-13){bus.Instr_D[31]}}, bus.Instr_D[31], bus.Instr_D[7],
               bus.Instr_D[30:25], bus.Instr_D[11:8], 1'b0};
      imm_j = {{(XLEN-21){bus.Instr_D[31]}}, bus.Instr_D[31], bus.Instr_D[19:12],
               bus.Instr_D[20], bus.Instr_D[30:21], 1'b0};

      // sub only exists in R-type; addi ignores bit 30 since it is immediate data.
      alu_ok = 1'b1;
      alu_op = 3'b000;
      case (funct3)
         3'b000: alu_op = (opcode == 7'b0110011 && bus.Instr_D[30]) ? 3'b001 : 3'b000;
         3'b010: alu_op = 3'b101;
         3'b110: alu_op = 3'b011;
         3'b111: alu_op = 3'b010;
         default: alu_ok = 1'b0;
      endcase

      idex_d            = '0;
      idex_d.rd1        = rf_read(rs1);
      idex_d.rd2        = rf_read(rs2);
      idex_d.rs1        = rs1;
      idex_d.rs2        = rs2;
      idex_d.rd         = bus.Instr_D[11:7];
      idex_d.pc         = bus.PC_D;
      idex_d.pc_plus    = bus.PCPlusD;

      case (opcode)
         7'b0000011: begin
            idex_d.reg_write  = 1'b1;
            idex_d.alu_src    = 1'b1;
            idex_d.result_src = 2'b01;
            idex_d.imm        = imm_i;
         end
         7'b0100011: begin
            idex_d.mem_write = 1'b1;
            idex_d.alu_src   = 1'b1;
            idex_d.imm       = imm_s;
         end
         7'b0110011: begin
            idex_d.reg_write = alu_ok;
            idex_d.alu_ctrl  = alu_ok ? alu_op : 3'b000;
            idex_d.illegal   = !alu_ok;
         end
         7'b0010011: begin
            idex_d.reg_write = alu_ok;
            idex_d.alu_src   = alu_ok;
            idex_d.alu_ctrl  = alu_ok ? alu_op : 3'b000;
            idex_d.imm       = imm_i;
            idex_d.illegal   = !alu_ok;
         end
         7'b1100011: begin
            idex_d.branch   = 1'b1;
            idex_d.alu_ctrl = 3'b001;
            idex_d.imm      = imm_b;
         end
         7'b1101111: begin
            idex_d.reg_write  = 1'b1;
            idex_d.jump       = 1'b1;
            idex_d.result_src = 2'b10;
            idex_d.imm        = imm_j;
         end
         default: idex_d.illegal = 1'b1;
      endcase
   end

   // ID/EX boundary
   always_ff @(posedge clk) begin
      if (rst || bus.FlushE)
         idex_q <= '0;
      else if (!bus.StallE)
         idex_q <= idex_d;
   end

   assign bus.RegWriteE   = idex_q.reg_write;
   assign bus.MemWriteE   = idex_q.mem_write;
   assign bus.JumpE       = idex_q.jump;
   assign bus.BranchE     = idex_q.branch;
   assign bus.ALUSrcE     = idex_q.alu_src;
   assign bus.ResultSrcE  = idex_q.result_src;
   assign bus.ALUControlE = idex_q.alu_ctrl;
   assign bus.RD1_E       = idex_q.rd1;
   assign bus.RD2_E       = idex_q.rd2;
   assign bus.ImmExtE     = idex_q.imm;
   assign bus.RS1_E       = idex_q.rs1;
   assign bus.RS2_E       = idex_q.rs2;
   assign bus.RD_E        = idex_q.rd;
   assign bus.PCE         = idex_q.pc;
   assign bus.PCPlusE     = idex_q.pc_plus;
   assign bus.IllegalE    = idex_q.illegal;
endmodule
